// File: rtl/ser_sched_if.sv
// ser_sched_if: CPU-side bus and the scheduler's private port onto one ser device.
// slave  = the scheduler's view, master = the CPU/device side that drives it.
interface ser_sched_if;
    logic        stb;
    logic        we;
    logic        addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;
    logic        s_stb;
    logic        s_we;
    logic        s_addr;
    logic [31:0] s_dout;
    logic [31:0] s_din;

    modport slave (
        input  stb, we, addr, data_in, s_din,
        output data_out, ack, s_stb, s_we, s_addr, s_dout
    );

    modport master (
        output stb, we, addr, data_in, s_din,
        input  data_out, ack, s_stb, s_we, s_addr, s_dout
    );
endinterface

// File: rtl/ser_sched.sv
// ser_sched: buffered scheduler in front of one ser serial device.
// Polls device status, drains RX bytes into a FIFO, feeds TX bytes from a FIFO,
// and (with SER_SCHED_CFG_EN defined) applies baud changes only once TX is empty.
//
// state | meaning
// ------+-----------------------------------------------------------
// GAP   | no device access; lets ser refresh its ready flags
// POLL  | read device status, pick the next access
// RD    | read received byte from device into RX FIFO
// WR    | write TX FIFO head to device
// CFG   | write pending baud code to device (SER_SCHED_CFG_EN only)
//
// Queued TX bytes drain before CFG is issued, so bytes written before a baud
// change go out at the old rate and the change lands on an idle line.
module ser_sched #(
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst,
    ser_sched_if.slave bus
);
    localparam logic [TX_DEPTH_LOG2:0] TX_FULL_XOR = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
    localparam logic [RX_DEPTH_LOG2:0] RX_FULL_XOR = {1'b1, {RX_DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {
        ST_GAP,
        ST_POLL,
        ST_RD,
        ST_WR
`ifdef SER_SCHED_CFG_EN
        , ST_CFG
`endif
    } state_t;

    state_t                 state;
    logic [7:0]             tx_mem [2**TX_DEPTH_LOG2];
    logic [7:0]             rx_mem [2**RX_DEPTH_LOG2];
    logic [TX_DEPTH_LOG2:0] tx_wp, tx_rp;
    logic [RX_DEPTH_LOG2:0] rx_wp, rx_rp;
    logic                   tx_empty, tx_full, rx_empty, rx_full;
    logic [7:0]             tx_head, rx_head;
    logic                   cpu_rd, cpu_wr, ctl_wr;
    logic                   tx_push, tx_pop, rx_push, rx_pop, rx_accept;
    logic                   rcv_rdy, xmt_rdy;
    logic                   tx_ovf, rx_ovf, cfg_pend;
    logic [31:0]            status;
    logic                   unused_bits;
`ifdef SER_SCHED_CFG_EN
    logic [2:0]             cfg_code;
`endif

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = ((tx_wp ^ tx_rp) == TX_FULL_XOR);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = ((rx_wp ^ rx_rp) == RX_FULL_XOR);
    assign tx_head  = tx_mem[tx_rp[TX_DEPTH_LOG2-1:0]];
    assign rx_head  = rx_mem[rx_rp[RX_DEPTH_LOG2-1:0]];

    assign cpu_rd    = bus.stb & ~bus.we;
    assign cpu_wr    = bus.stb & bus.we;
    assign ctl_wr    = cpu_wr & bus.addr;
    assign tx_push   = cpu_wr & ~bus.addr;
    assign tx_pop    = (state == ST_WR) & ~tx_empty;
    assign rx_pop    = cpu_rd & ~bus.addr & ~rx_empty;
    assign rx_push   = (state == ST_RD);
    // A CPU pop on the same edge frees the slot the device byte lands in.
    assign rx_accept = rx_push & (~rx_full | rx_pop);

    assign rcv_rdy = bus.s_din[0];
    assign xmt_rdy = bus.s_din[1];

    assign status      = {26'h0, cfg_pend, tx_ovf, rx_ovf, tx_empty, ~tx_full, ~rx_empty};
    assign bus.ack     = bus.stb;
    assign unused_bits = ^{bus.s_din[31:8], bus.data_in[31:9]};

    // CPU read mux: data pops RX head, control returns status, 0 otherwise.
    always_comb begin
        bus.data_out = 32'h0;
        if (cpu_rd) begin
            if (bus.addr)
                bus.data_out = status;
            else if (!rx_empty)
                bus.data_out = {24'h0, rx_head};
        end
    end

    // Device-side access decoded from the current state; silent in reset.
    always_comb begin
        bus.s_stb  = 1'b0;
        bus.s_we   = 1'b0;
        bus.s_addr = 1'b0;
        bus.s_dout = 32'h0;
        if (!rst) begin
            case (state)
                ST_POLL: begin
                    bus.s_stb  = 1'b1;
                    bus.s_addr = 1'b1;
                end
                ST_RD: begin
                    bus.s_stb  = 1'b1;
                end
                ST_WR: begin
                    bus.s_stb  = 1'b1;
                    bus.s_we   = 1'b1;
                    bus.s_dout = {24'h0, tx_head};
                end
`ifdef SER_SCHED_CFG_EN
                ST_CFG: begin
                    bus.s_stb  = 1'b1;
                    bus.s_we   = 1'b1;
                    bus.s_addr = 1'b1;
                    bus.s_dout = {29'h0, cfg_code};
                end
`endif
                default: ;
            endcase
        end
    end

    // FIFO storage; contents are meaningless once the pointers reset.
    always_ff @(posedge clk) begin
        if (tx_push && !tx_full)
            tx_mem[tx_wp[TX_DEPTH_LOG2-1:0]] <= bus.data_in[7:0];
        if (rx_accept)
            rx_mem[rx_wp[RX_DEPTH_LOG2-1:0]] <= bus.s_din[7:0];
    end

    // FIFO pointers and sticky overflow flags; a new overflow beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (tx_push && !tx_full)
                tx_wp <= tx_wp + (TX_DEPTH_LOG2+1)'(1);
            if (tx_pop)
                tx_rp <= tx_rp + (TX_DEPTH_LOG2+1)'(1);
            if (rx_accept)
                rx_wp <= rx_wp + (RX_DEPTH_LOG2+1)'(1);
            if (rx_pop)
                rx_rp <= rx_rp + (RX_DEPTH_LOG2+1)'(1);
            if (ctl_wr && bus.data_in[8]) begin
                tx_ovf <= 1'b0;
                rx_ovf <= 1'b0;
            end
            if (tx_push && tx_full)
                tx_ovf <= 1'b1;
            if (rx_push && !rx_accept)
                rx_ovf <= 1'b1;
        end
    end

`ifdef SER_SCHED_CFG_EN
    // Pending baud code; a CPU write on the CFG edge re-arms with the new code.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_pend <= 1'b0;
            cfg_code <= 3'h7;
        end else begin
            if (state == ST_CFG)
                cfg_pend <= 1'b0;
            if (ctl_wr) begin
                cfg_code <= bus.data_in[2:0];
                cfg_pend <= 1'b1;
            end
        end
    end
`else
    assign cfg_pend = 1'b0;
`endif

    // Device sequencing: every access is followed by GAP, then POLL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_GAP;
        end else begin
            case (state)
                ST_GAP:  state <= ST_POLL;
                ST_POLL: begin
`ifdef SER_SCHED_CFG_EN
                    if (cfg_pend && tx_empty && xmt_rdy)
                        state <= ST_CFG;
                    else
`endif
                    if (rcv_rdy)
                        state <= ST_RD;
                    else if (xmt_rdy && !tx_empty)
                        state <= ST_WR;
                    else
                        state <= ST_GAP;
                end
                default: state <= ST_GAP;
            endcase
        end
    end
endmodule

// File: tb/tb_ser_sched.sv
// tb_ser_sched: directed and randomized checks of ser_sched against a
// queue-based reference model of the scheduler's device accesses.
module tb_ser_sched;
    localparam int TXD    = 16;
    localparam int RXD    = 16;
    localparam int A_GAP  = 0;
    localparam int A_POLL = 1;
    localparam int A_RD   = 2;
    localparam int A_WR   = 3;
    localparam int A_CFG  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dev_st = 2'b00;
    logic [7:0] dev_by = 8'h00;
    logic [1:0] g_st = 2'b00;
    logic [7:0] g_by = 8'h00;
    bit         dev_clr_rcv = 1'b0;

    int checks = 0;
    int errors = 0;

    // reference model
    int         acc = A_GAP;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       tx_ovf_m = 1'b0;
    logic       rx_ovf_m = 1'b0;
    logic       cfg_pend_m = 1'b0;
    logic [2:0] cfg_code_m = 3'h7;

    // observations from the latest cycle
    logic [31:0] o_dout;
    logic        o_stb;
    logic [31:0] wr_seen[$];
    logic [31:0] cfg_seen[$];
    int          acc_log[$];

    always #5 clk = ~clk;

    ser_sched_if bus();

    // Device answers status on addr 1 and its received byte on addr 0.
    assign bus.s_din = bus.s_addr ? {30'h0, dev_st} : {24'h0, dev_by};

    ser_sched #(.TX_DEPTH_LOG2(4), .RX_DEPTH_LOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] status_m();
        return {26'h0, cfg_pend_m, tx_ovf_m, rx_ovf_m,
                (tx_q.size() == 0), (tx_q.size() < TXD), (rx_q.size() > 0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic c_rst, input logic c_stb, input logic c_we,
                         input logic c_addr, input logic [31:0] c_din);
        logic [2:0]  e_ctl;
        logic [31:0] e_sdout;
        logic [31:0] e_dout;
        int          nxt;
        logic        tx_push, ctl_wr, tx_was_full;
        @(negedge clk);
        rst         = c_rst;
        bus.stb     = c_stb;
        bus.we      = c_we;
        bus.addr    = c_addr;
        bus.data_in = c_din;
        dev_st      = g_st;
        dev_by      = g_by;
        #1;
        e_ctl   = 3'b000;
        e_sdout = 32'h0;
        if (!c_rst) begin
            case (acc)
                A_POLL: e_ctl = 3'b101;
                A_RD:   e_ctl = 3'b100;
                A_WR:   begin e_ctl = 3'b110; e_sdout = {24'h0, tx_q[0]}; end
                A_CFG:  begin e_ctl = 3'b111; e_sdout = {29'h0, cfg_code_m}; end
                default: ;
            endcase
        end
        e_dout = 32'h0;
        if (c_stb && !c_we)
            e_dout = c_addr ? status_m() : ((rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'h0);
        check("s_ctl", {29'h0, bus.s_stb, bus.s_we, bus.s_addr}, {29'h0, e_ctl});
        check("s_dout", bus.s_dout, e_sdout);
        check("data_out", bus.data_out, e_dout);
        check("ack", {31'h0, bus.ack}, {31'h0, c_stb});
        o_dout = bus.data_out;
        o_stb  = bus.s_stb;
        if (bus.s_stb && !bus.s_we && !bus.s_addr) begin
            acc_log.push_back(A_RD);
            if (dev_clr_rcv) g_st[0] = 1'b0;
        end
        if (bus.s_stb && bus.s_we && !bus.s_addr) begin
            acc_log.push_back(A_WR);
            wr_seen.push_back(bus.s_dout);
        end
        if (bus.s_stb && bus.s_we && bus.s_addr) begin
            acc_log.push_back(A_CFG);
            cfg_seen.push_back(bus.s_dout);
        end
        // model the effect of the coming edge
        if (c_rst) begin
            tx_q.delete();
            rx_q.delete();
            tx_ovf_m   = 1'b0;
            rx_ovf_m   = 1'b0;
            cfg_pend_m = 1'b0;
            cfg_code_m = 3'h7;
            acc        = A_GAP;
        end else begin
            nxt = A_GAP;
            if (acc == A_GAP)
                nxt = A_POLL;
            else if (acc == A_POLL) begin
                if (cfg_pend_m && tx_q.size() == 0 && g_st[1]) nxt = A_CFG;
                else if (g_st[0])                             nxt = A_RD;
                else if (g_st[1] && tx_q.size() > 0)          nxt = A_WR;
            end
            ctl_wr      = c_stb && c_we && c_addr;
            tx_push     = c_stb && c_we && !c_addr;
            tx_was_full = (tx_q.size() == TXD);
            if (ctl_wr && c_din[8]) begin
                tx_ovf_m = 1'b0;
                rx_ovf_m = 1'b0;
            end
            if (c_stb && !c_we && !c_addr && rx_q.size() > 0)
                void'(rx_q.pop_front());
            if (acc == A_RD) begin
                if (rx_q.size() < RXD) rx_q.push_back(g_by);
                else                   rx_ovf_m = 1'b1;
            end
            if (acc == A_WR)
                void'(tx_q.pop_front());
            if (tx_push) begin
                if (tx_was_full) tx_ovf_m = 1'b1;
                else             tx_q.push_back(c_din[7:0]);
            end
`ifdef SER_SCHED_CFG_EN
            if (acc == A_CFG) cfg_pend_m = 1'b0;
            if (ctl_wr) begin
                cfg_code_m = c_din[2:0];
                cfg_pend_m = 1'b1;
            end
`endif
            acc = nxt;
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic cpu_wr(input logic a, input logic [31:0] d);
        cycle(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic cpu_rd(input logic a);
        cycle(1'b0, 1'b1, 1'b0, a, 32'h0);
    endtask

    initial begin
        logic [4:0]  hist;
        logic [31:0] last;
        bit          done;
        bus.stb     = 1'b0;
        bus.we      = 1'b0;
        bus.addr    = 1'b0;
        bus.data_in = 32'h0;

        // reset and idle polling
        g_st = 2'b10;
        do_reset(3);
        hist = 5'b0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            hist = {hist[3:0], o_stb};
        end
        check("idle_stb_pattern", {27'h0, hist}, 32'h0000000A);
        cpu_rd(1'b1);
        check("idle_status", o_dout, 32'h6);

        // two queued bytes go out in order
        wr_seen.delete();
        cpu_wr(1'b0, 32'h41);
        cpu_wr(1'b0, 32'h42);
        idle(12);
        check("wr_count", 32'(wr_seen.size()), 32'd2);
        if (wr_seen.size() >= 2) begin
            check("wr_first", wr_seen[0], 32'h41);
            check("wr_second", wr_seen[1], 32'h42);
        end
        cpu_rd(1'b1);
        check("status_after_wr", o_dout, 32'h6);

        // TX overflow, clear, then reset discards the queue
        g_st = 2'b00;
        for (int i = 0; i < 17; i++) cpu_wr(1'b0, 32'(8'h80 + i));
        cpu_rd(1'b1);
        check("tx_full_status", o_dout, 32'h10);
        cpu_wr(1'b1, 32'h100);
        cpu_rd(1'b1);
`ifdef SER_SCHED_CFG_EN
        check("tx_ovf_cleared", o_dout, 32'h20);
`else
        check("tx_ovf_cleared", o_dout, 32'h0);
`endif
        do_reset(2);
        cpu_rd(1'b1);
        check("reset_discards", o_dout, 32'h6);

        // RD outranks WR in the same poll
        cpu_wr(1'b0, 32'h77);
        idle(3);
        acc_log.delete();
        wr_seen.delete();
        g_st = 2'b11;
        g_by = 8'h5A;
        dev_clr_rcv = 1'b1;
        idle(10);
        dev_clr_rcv = 1'b0;
        g_st = 2'b00;
        check("acc_count", 32'(acc_log.size()), 32'd2);
        if (acc_log.size() >= 2) begin
            check("acc_first_rd", 32'(acc_log[0]), 32'(A_RD));
            check("acc_second_wr", 32'(acc_log[1]), 32'(A_WR));
        end
        if (wr_seen.size() >= 1) check("wr_after_rd", wr_seen[0], 32'h77);
        cpu_rd(1'b0);
        check("rx_byte", o_dout, 32'h5A);

        // RX full: pop and device read on one edge keep the count
        g_by = 8'hA0;
        g_st = 2'b01;
        for (int i = 0; i < 120 && rx_q.size() < RXD; i++) idle(1);
        g_st = 2'b00;
        cpu_rd(1'b1);
        check("rx_full_status", o_dout, 32'h7);
        g_by = 8'hEE;
        g_st = 2'b01;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (acc == A_RD) begin
                cpu_rd(1'b0);
                done = 1'b1;
                g_st = 2'b00;
                check("bypass_pop_val", o_dout, 32'hA0);
            end else begin
                idle(1);
            end
        end
        check("bypass_reached", {31'h0, done}, 32'h1);
        idle(2);
        cpu_rd(1'b1);
        check("bypass_no_ovf", o_dout, 32'h7);
        last = 32'h0;
        for (int i = 0; i < 16; i++) begin
            cpu_rd(1'b0);
            last = o_dout;
        end
        check("bypass_last_byte", last, 32'hEE);
        cpu_rd(1'b0);
        check("rx_empty_read", o_dout, 32'h0);

        // RX overflow without a pop
        g_by = 8'h33;
        g_st = 2'b01;
        for (int i = 0; i < 120 && rx_q.size() < RXD; i++) idle(1);
        idle(4);
        g_st = 2'b00;
        idle(2);
        cpu_rd(1'b1);
        check("rx_ovf_status", o_dout, 32'hF);
        cpu_wr(1'b1, 32'h100);
        cpu_rd(1'b1);
`ifdef SER_SCHED_CFG_EN
        check("rx_ovf_cleared", o_dout, 32'h27);
`else
        check("rx_ovf_cleared", o_dout, 32'h7);
`endif
        do_reset(2);

`ifdef SER_SCHED_CFG_EN
        // baud change waits for TX to drain, issued exactly once
        g_st = 2'b00;
        cpu_wr(1'b0, 32'h11);
        cpu_wr(1'b0, 32'h22);
        cpu_wr(1'b1, 32'h2);
        acc_log.delete();
        wr_seen.delete();
        cfg_seen.delete();
        g_st = 2'b10;
        for (int i = 0; i < 20; i++) cpu_rd(1'b1);
        check("cfg_acc_count", 32'(acc_log.size()), 32'd3);
        if (acc_log.size() >= 3) check("cfg_last", 32'(acc_log[2]), 32'(A_CFG));
        check("cfg_once", 32'(cfg_seen.size()), 32'd1);
        if (cfg_seen.size() >= 1) check("cfg_code", cfg_seen[0], 32'h2);
        check("cfg_status_after", o_dout, 32'h6);
        do_reset(2);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            int op;
            op   = $urandom_range(0, 7);
            g_st = 2'($urandom_range(0, 3));
            g_by = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1);
            end else begin
                case (op)
                    3, 7: cpu_wr(1'b0, 32'($urandom_range(0, 255)));
                    4:    cpu_rd(1'b0);
                    5:    cpu_rd(1'b1);
                    6:    cpu_wr(1'b1, 32'($urandom_range(0, 511)));
                    default: idle(1);
                endcase
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
